// File: rtl/div_pkg.sv
// Shared types and helpers for the programmable strobe/clock-enable divider.
package div_pkg;

  typedef enum logic {IDLE, RUN} div_state_t;

  localparam int unsigned MIN_DIV   = 2;
  // high_time() works at a fixed width, so the divider WIDTH must not exceed MAX_WIDTH.
  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned HT_W      = MAX_WIDTH + 1;

  // High phase of an N-cycle period; odd N gets the longer high phase.
  function automatic logic [HT_W-1:0] high_time(input logic [MAX_WIDTH-1:0] n);
    return (HT_W'(n) + HT_W'(1)) >> 1;
  endfunction

endpackage

// File: rtl/div_ratio_shadow.sv
// Double-buffered ratio register: a requested ratio is held pending and only
// committed when the owner signals a safe boundary via apply.
module div_ratio_shadow #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  input  logic             apply,
  output logic [WIDTH-1:0] div_reg,
  output logic             load_ack
);

  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic [WIDTH-1:0] div_reg_q, div_reg_d;
  logic             load_ack_q, load_ack_d;
  logic             fire;

  // Only a request that was already pending before this edge may commit.
  assign fire = apply & pend_q;

  always_comb begin
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    div_reg_d  = div_reg_q;
    load_ack_d = 1'b0;
    if (fire) begin
      div_reg_d  = pend_val_q;
      pend_d     = 1'b0;
      load_ack_d = 1'b1;
    end
    if (load) begin
      pend_val_d = div;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pend_q     <= 1'b0;
      pend_val_q <= WIDTH'(DEFAULT_DIV);
      div_reg_q  <= WIDTH'(DEFAULT_DIV);
      load_ack_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      div_reg_q  <= div_reg_d;
      load_ack_q <= load_ack_d;
    end
  end

  assign div_reg  = div_reg_q;
  assign load_ack = load_ack_q;

endmodule

// File: rtl/div_gen.sv
// Programmable divider producing a registered square/pulse output and a
// period-start tick, with ratio changes committed only at period boundaries.
//   state | meaning
//   IDLE  | not yet enabled since reset; outputs low, pending ratio applied freely
//   RUN   | counting 0..N-1; en=0 freezes count and q, suppresses tick
module div_gen import div_pkg::*; #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] div,
  input  logic             load,
  output logic             load_ack,
  output logic             q,
  output logic             tick
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] n_eff;
  logic [HT_W-1:0]  h_full;
  logic             wrap;
  logic             apply;

  div_ratio_shadow #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_shadow (
    .clk      (clk),
    .clear    (clear),
    .load     (load),
    .div      (div),
    .apply    (apply),
    .div_reg  (div_reg),
    .load_ack (load_ack)
  );

  assign n_eff  = (div_reg < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_reg;
  assign h_full = high_time(MAX_WIDTH'(n_eff));
  assign wrap   = (cnt_q == (n_eff - WIDTH'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    tick_d  = 1'b0;
    apply   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        q_d   = 1'b0;
        apply = 1'b1;
        if (en) begin
          state_d = RUN;
          q_d     = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN: begin
        if (en) begin
          cnt_d  = wrap ? '0 : cnt_q + WIDTH'(1);
          tick_d = (cnt_d == '0);
          q_d    = mode ? (cnt_d == '0) : (HT_W'(cnt_d) < h_full);
          apply  = (cnt_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      tick_q  <= tick_d;
    end
  end

  assign q    = q_q;
  assign tick = tick_q;

endmodule
